// File: rtl/eth_stream_sched.sv
// rtl/eth_stream_sched.sv - multi-stream frame profile scheduler in front of the packet generator
//
// Purpose: holds NUM_STREAMS frame profiles, loads one at a time into the
// generator config outputs, runs it to send_done, waits for the wire to go
// idle, then moves on to the next enabled stream (optionally looping).
//
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   io_start / io_stop / io_loop   schedule control
//   io_stream_mask                 per-stream enable, sampled on each selection
//   io_cfg_*                       profile table write port
//   io_gen_*  (out)                latched profile and enable for the generator
//   io_gen_send_done, io_gen_tx_en generator status
//   io_busy, io_cur_stream, io_done, io_pass_cnt   scheduler status
module eth_stream_sched #(
   parameter int NUM_STREAMS = 4,
   parameter int IDX_W       = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   io_start,
   input  logic                   io_stop,
   input  logic                   io_loop,
   input  logic [NUM_STREAMS-1:0] io_stream_mask,
   input  logic                   io_cfg_we,
   input  logic [IDX_W-1:0]       io_cfg_idx,
   input  logic [47:0]            io_cfg_da,
   input  logic [47:0]            io_cfg_sa,
   input  logic [15:0]            io_cfg_etype,
   input  logic [15:0]            io_cfg_pkt_len,
   input  logic [1:0]             io_cfg_payload_mode,
   input  logic [31:0]            io_cfg_count,
   output logic                   io_gen_enable,
   output logic [47:0]            io_gen_da,
   output logic [47:0]            io_gen_sa,
   output logic [15:0]            io_gen_etype,
   output logic [15:0]            io_gen_pkt_len_init,
   output logic [1:0]             io_gen_payload_mode,
   output logic [31:0]            io_gen_send_count,
   input  logic                   io_gen_send_done,
   input  logic                   io_gen_tx_en,
   output logic                   io_busy,
   output logic [IDX_W-1:0]       io_cur_stream,
   output logic                   io_done,
   output logic [15:0]            io_pass_cnt
);

   typedef struct packed {
      logic [47:0] da;
      logic [47:0] sa;
      logic [15:0] etype;
      logic [15:0] pkt_len;
      logic [1:0]  payload_mode;
      logic [31:0] cnt;
   } profile_t;

   typedef enum logic [2:0] {S_IDLE, S_SEL, S_LOAD, S_RUN, S_DRAIN} state_t;

   localparam logic [IDX_W:0] NUM_S = (IDX_W+1)'(NUM_STREAMS);

   profile_t         tbl_q [NUM_STREAMS];
   profile_t         gen_q;
   profile_t         cfg_entry;
   state_t           state_q;
   logic [IDX_W-1:0] cursor_q;
   logic             cur_valid_q;   // 0 = cursor is "-1", search starts below index 0
   logic             first_run_q;   // first RUN cycle, send_done may be stale
   logic             stop_pend_q;
   logic             enable_q;
   logic             done_q;
   logic [15:0]      pass_q;
   logic [IDX_W-1:0] cur_stream_q;

   logic             hit_after;
   logic [IDX_W-1:0] idx_after;
   logic             hit_any;
   logic [IDX_W-1:0] idx_first;

   assign cfg_entry = '{da: io_cfg_da, sa: io_cfg_sa, etype: io_cfg_etype,
                        pkt_len: io_cfg_pkt_len, payload_mode: io_cfg_payload_mode,
                        cnt: io_cfg_count};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_STREAMS; i++) tbl_q[i] <= '0;
      end else if (io_cfg_we && ({1'b0, io_cfg_idx} < NUM_S)) begin
         tbl_q[io_cfg_idx] <= cfg_entry;
      end
   end

   // Lowest set mask bit above the cursor, and lowest set bit overall (used on wrap).
   always_comb begin
      hit_after = 1'b0;
      idx_after = '0;
      hit_any   = 1'b0;
      idx_first = '0;
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (io_stream_mask[i]) begin
            hit_any   = 1'b1;
            idx_first = IDX_W'(i);
            if (!cur_valid_q || (IDX_W'(i) > cursor_q)) begin
               hit_after = 1'b1;
               idx_after = IDX_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cursor_q     <= '0;
         cur_valid_q  <= 1'b0;
         first_run_q  <= 1'b0;
         stop_pend_q  <= 1'b0;
         enable_q     <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= '0;
         gen_q        <= '0;
         cur_stream_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (io_start && !io_stop && (io_stream_mask != '0)) begin
                  cur_valid_q <= 1'b0;
                  stop_pend_q <= 1'b0;
                  state_q     <= S_SEL;
               end
            end
            S_SEL: begin
               if (io_stop || !hit_any || (!hit_after && !io_loop)) begin
                  state_q     <= S_IDLE;
                  done_q      <= 1'b1;
                  stop_pend_q <= 1'b0;
               end else if (hit_after) begin
                  cursor_q    <= idx_after;
                  cur_valid_q <= 1'b1;
                  state_q     <= S_LOAD;
               end else begin
                  // Search ran past the top index in loop mode: one full pass done.
                  pass_q      <= pass_q + 16'd1;
                  cursor_q    <= idx_first;
                  cur_valid_q <= 1'b1;
                  state_q     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (io_stop) begin
                  state_q     <= S_IDLE;
                  done_q      <= 1'b1;
                  stop_pend_q <= 1'b0;
               end else begin
                  gen_q        <= tbl_q[cursor_q];
                  cur_stream_q <= cursor_q;
                  if (tbl_q[cursor_q].cnt == 32'd0) begin
                     state_q <= S_SEL;
                  end else begin
                     state_q     <= S_RUN;
                     enable_q    <= 1'b1;
                     first_run_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               first_run_q <= 1'b0;
               if (io_stop) begin
                  stop_pend_q <= 1'b1;
                  enable_q    <= 1'b0;
                  state_q     <= S_DRAIN;
               end else if (!first_run_q && io_gen_send_done) begin
                  enable_q <= 1'b0;
                  state_q  <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (io_stop) stop_pend_q <= 1'b1;
               if (!io_gen_tx_en) begin
                  if (stop_pend_q || io_stop) begin
                     state_q     <= S_IDLE;
                     done_q      <= 1'b1;
                     stop_pend_q <= 1'b0;
                  end else begin
                     state_q <= S_SEL;
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               enable_q <= 1'b0;
            end
         endcase
      end
   end

   assign io_gen_enable       = enable_q;
   assign io_gen_da           = gen_q.da;
   assign io_gen_sa           = gen_q.sa;
   assign io_gen_etype        = gen_q.etype;
   assign io_gen_pkt_len_init = gen_q.pkt_len;
   assign io_gen_payload_mode = gen_q.payload_mode;
   assign io_gen_send_count   = gen_q.cnt;
   assign io_busy             = (state_q != S_IDLE);
   assign io_cur_stream       = cur_stream_q;
   assign io_done             = done_q;
   assign io_pass_cnt         = pass_q;

endmodule

// File: tb/tb_eth_stream_sched.sv
// tb/tb_eth_stream_sched.sv - randomized self-checking bench for eth_stream_sched
module tb_eth_stream_sched;
   localparam int N = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          io_start, io_stop, io_loop;
   logic [N-1:0]  io_stream_mask;
   logic          io_cfg_we;
   logic [1:0]    io_cfg_idx;
   logic [47:0]   io_cfg_da, io_cfg_sa;
   logic [15:0]   io_cfg_etype, io_cfg_pkt_len;
   logic [1:0]    io_cfg_payload_mode;
   logic [31:0]   io_cfg_count;
   logic          io_gen_enable;
   logic [47:0]   io_gen_da, io_gen_sa;
   logic [15:0]   io_gen_etype, io_gen_pkt_len_init;
   logic [1:0]    io_gen_payload_mode;
   logic [31:0]   io_gen_send_count;
   logic          io_gen_send_done, io_gen_tx_en;
   logic          io_busy;
   logic [1:0]    io_cur_stream;
   logic          io_done;
   logic [15:0]   io_pass_cnt;

   always #5 clock = ~clock;

   eth_stream_sched #(.NUM_STREAMS(N), .IDX_W(2)) dut (
      .clock(clock), .reset_n(reset_n), .io_start(io_start), .io_stop(io_stop), .io_loop(io_loop),
      .io_stream_mask(io_stream_mask), .io_cfg_we(io_cfg_we), .io_cfg_idx(io_cfg_idx),
      .io_cfg_da(io_cfg_da), .io_cfg_sa(io_cfg_sa), .io_cfg_etype(io_cfg_etype),
      .io_cfg_pkt_len(io_cfg_pkt_len), .io_cfg_payload_mode(io_cfg_payload_mode),
      .io_cfg_count(io_cfg_count), .io_gen_enable(io_gen_enable), .io_gen_da(io_gen_da),
      .io_gen_sa(io_gen_sa), .io_gen_etype(io_gen_etype), .io_gen_pkt_len_init(io_gen_pkt_len_init),
      .io_gen_payload_mode(io_gen_payload_mode), .io_gen_send_count(io_gen_send_count),
      .io_gen_send_done(io_gen_send_done), .io_gen_tx_en(io_gen_tx_en), .io_busy(io_busy),
      .io_cur_stream(io_cur_stream), .io_done(io_done), .io_pass_cnt(io_pass_cnt)
   );

   int checks = 0;
   int failures = 0;

   // Reference copy of the profile table.
   logic [47:0] m_da  [N];
   logic [47:0] m_sa  [N];
   logic [15:0] m_et  [N];
   logic [15:0] m_len [N];
   logic [1:0]  m_pm  [N];
   logic [31:0] m_cnt [N];

   typedef struct {
      int          idx;
      logic [47:0] da;
      logic [47:0] sa;
      logic [15:0] et;
      logic [15:0] len;
      logic [1:0]  pm;
      logic [31:0] cnt;
   } visit_t;

   visit_t visits[$];
   visit_t mon_v;
   int     done_cnt = 0;
   int     en_on_1 = 0;
   int     g_early = 0;
   bit     en_prev = 1'b0;

   // Behavioural generator: runs count*k cycles of wire activity, then raises
   // send_done, optionally holding it (stale) into the next stream's first cycle.
   bit gen_auto = 1'b0;
   bit hold_stale = 1'b1;
   bit g_run = 1'b0;
   bit g_fin = 1'b0;
   int g_left = 0;
   int g_tail = 0;

   always @(negedge clock) begin
      if (!reset_n || !gen_auto) begin
         g_run = 1'b0; g_fin = 1'b0; g_tail = 0;
         if (!reset_n && gen_auto) begin io_gen_tx_en = 1'b0; io_gen_send_done = 1'b0; end
      end else if (io_gen_enable) begin
         if (!g_run && !g_fin) begin
            g_run = 1'b1;
            g_left = int'(io_gen_send_count) * int'($urandom_range(2, 4));
            io_gen_tx_en = 1'b1;
         end else if (g_run) begin
            io_gen_send_done = 1'b0;
            g_left--;
            if (g_left <= 0) begin
               g_run = 1'b0; g_fin = 1'b1; io_gen_send_done = 1'b1;
               g_tail = int'($urandom_range(0, 3));
               io_gen_tx_en = (g_tail > 0);
            end
         end else begin
            if (g_tail > 0) g_tail--;
            io_gen_tx_en = (g_tail > 0);
         end
      end else begin
         if (g_run) begin g_early++; g_run = 1'b0; end
         g_fin = 1'b0;
         if (g_tail > 0) g_tail--;
         io_gen_tx_en = (g_tail > 0);
         if (!hold_stale) io_gen_send_done = 1'b0;
      end
   end

   always @(negedge clock) begin
      if (!reset_n) begin
         en_prev = 1'b0;
      end else begin
         if (io_gen_enable && !en_prev) begin
            mon_v.idx = int'(io_cur_stream); mon_v.da = io_gen_da; mon_v.sa = io_gen_sa;
            mon_v.et = io_gen_etype; mon_v.len = io_gen_pkt_len_init;
            mon_v.pm = io_gen_payload_mode; mon_v.cnt = io_gen_send_count;
            visits.push_back(mon_v);
         end
         if (io_done) done_cnt++;
         if (io_gen_enable && io_cur_stream == 2'd1) en_on_1++;
         en_prev = io_gen_enable;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(negedge clock); #1; end
   endtask

   task automatic clear_mon();
      visits.delete(); done_cnt = 0; en_on_1 = 0; g_early = 0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; io_start = 1'b0; io_stop = 1'b0; io_loop = 1'b0; io_stream_mask = '0;
      io_cfg_we = 1'b0; io_cfg_idx = '0; io_cfg_da = '0; io_cfg_sa = '0; io_cfg_etype = '0;
      io_cfg_pkt_len = '0; io_cfg_payload_mode = '0; io_cfg_count = '0;
      io_gen_send_done = 1'b0; io_gen_tx_en = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_da[i] = '0; m_sa[i] = '0; m_et[i] = '0; m_len[i] = '0; m_pm[i] = '0; m_cnt[i] = '0;
      end
      tick(2);
      reset_n = 1'b1;
      tick(1);
      clear_mon();
   endtask

   task automatic write_entry(input int idx, input logic [47:0] da, input logic [47:0] sa,
                              input logic [15:0] et, input logic [15:0] len,
                              input logic [1:0] pm, input logic [31:0] cnt);
      io_cfg_we = 1'b1; io_cfg_idx = 2'(idx); io_cfg_da = da; io_cfg_sa = sa;
      io_cfg_etype = et; io_cfg_pkt_len = len; io_cfg_payload_mode = pm; io_cfg_count = cnt;
      tick();
      io_cfg_we = 1'b0;
      m_da[idx] = da; m_sa[idx] = sa; m_et[idx] = et; m_len[idx] = len; m_pm[idx] = pm; m_cnt[idx] = cnt;
   endtask

   task automatic rand_entry(input int idx, input int cnt);
      write_entry(idx, {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF | 48'h1,
                  {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF,
                  16'($urandom()), 16'($urandom_range(64, 1518)), 2'($urandom()), 32'(cnt));
   endtask

   task automatic pulse_start();
      io_start = 1'b1; tick(); io_start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; io_start = 1'b0; io_stop = 1'b0; io_loop = 1'b0; io_stream_mask = '0;
      io_cfg_we = 1'b0; io_cfg_idx = '0; io_cfg_da = '0; io_cfg_sa = '0; io_cfg_etype = '0;
      io_cfg_pkt_len = '0; io_cfg_payload_mode = '0; io_cfg_count = '0;
      io_gen_send_done = 1'b0; io_gen_tx_en = 1'b0;
      tick(2);
      checks++; if (io_gen_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", io_gen_enable); end
      checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", io_busy); end
      checks++; if (io_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", io_done); end
      checks++; if (io_pass_cnt !== 16'd0) begin failures++; $display("FAIL reset_pass_cnt got=%0h exp=0", io_pass_cnt); end
      checks++; if (io_cur_stream !== 2'd0) begin failures++; $display("FAIL reset_cur_stream got=%0h exp=0", io_cur_stream); end
      checks++; if (io_gen_da !== 48'd0) begin failures++; $display("FAIL reset_gen_da got=%0h exp=0", io_gen_da); end
      checks++; if (io_gen_send_count !== 32'd0) begin failures++; $display("FAIL reset_send_count got=%0h exp=0", io_gen_send_count); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_pass();
      int exp_idx[$];
      logic [3:0] mask;
      int lim;
      gen_auto = 1'b1; hold_stale = 1'b1;
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         mask = (r == 0) ? 4'b0101 : 4'($urandom_range(1, 15));
         for (int e = 0; e < N; e++) rand_entry(e, (r == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
         exp_idx.delete();
         for (int e = 0; e < N; e++) if (mask[e] && m_cnt[e] != 0) exp_idx.push_back(e);
         clear_mon();
         io_stream_mask = mask; io_loop = 1'b0;
         pulse_start();
         if (r == 0) begin
            tick();
            checks++; if (io_gen_enable !== 1'b0) begin failures++; $display("FAIL latency_load_enable got=%b exp=0", io_gen_enable); end
            tick();
            checks++; if (io_gen_enable !== 1'b1) begin failures++; $display("FAIL latency_run_enable got=%b exp=1", io_gen_enable); end
         end
         lim = 0;
         while (done_cnt == 0 && lim < 3000) begin tick(); lim++; end
         tick(3);
         checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done_count r=%0d got=%0d exp=1", r, done_cnt); end
         checks++; if (visits.size() != exp_idx.size()) begin failures++; $display("FAIL single_visit_count r=%0d got=%0d exp=%0d", r, visits.size(), exp_idx.size()); end
         for (int k = 0; k < visits.size() && k < exp_idx.size(); k++) begin
            int e;
            e = exp_idx[k];
            checks++; if (visits[k].idx != e) begin failures++; $display("FAIL single_visit_idx r=%0d k=%0d got=%0d exp=%0d", r, k, visits[k].idx, e); end
            checks++;
            if (visits[k].da !== m_da[e] || visits[k].sa !== m_sa[e] || visits[k].et !== m_et[e] ||
                visits[k].len !== m_len[e] || visits[k].pm !== m_pm[e] || visits[k].cnt !== m_cnt[e]) begin
               failures++;
               $display("FAIL single_visit_profile r=%0d k=%0d got da=%0h cnt=%0d exp da=%0h cnt=%0d", r, k, visits[k].da, visits[k].cnt, m_da[e], m_cnt[e]);
            end
         end
         checks++; if (g_early != 0) begin failures++; $display("FAIL single_early_end r=%0d got=%0d exp=0", r, g_early); end
         checks++; if (io_pass_cnt !== 16'd0) begin failures++; $display("FAIL single_pass_cnt got=%0d exp=0", io_pass_cnt); end
         checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", io_busy); end
      end
   endtask

   task automatic test_loop();
      int lim;
      int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
      gen_auto = 1'b1; hold_stale = 1'b1;
      apply_reset();
      rand_entry(0, int'($urandom_range(1, 2)));
      rand_entry(1, int'($urandom_range(1, 2)));
      clear_mon();
      io_stream_mask = 4'b0011; io_loop = 1'b1;
      pulse_start();
      lim = 0;
      while (visits.size() < 5 && lim < 3000) begin tick(); lim++; end
      checks++; if (visits.size() < 5) begin failures++; $display("FAIL loop_wait_pass3 got=%0d visits exp=5", visits.size()); end
      checks++; if (io_pass_cnt !== 16'd2) begin failures++; $display("FAIL loop_pass_cnt got=%0d exp=2", io_pass_cnt); end
      checks++; if (g_early != 0) begin failures++; $display("FAIL loop_early_end got=%0d exp=0", g_early); end
      lim = 0;
      while (visits.size() < 6 && lim < 3000) begin tick(); lim++; end
      io_stop = 1'b1; tick(); io_stop = 1'b0;
      lim = 0;
      while (done_cnt == 0 && lim < 100) begin tick(); lim++; end
      tick(2);
      checks++; if (visits.size() != 6) begin failures++; $display("FAIL loop_visit_count got=%0d exp=6", visits.size()); end
      for (int k = 0; k < 6 && k < visits.size(); k++) begin
         checks++; if (visits[k].idx != exp_seq[k]) begin failures++; $display("FAIL loop_seq k=%0d got=%0d exp=%0d", k, visits[k].idx, exp_seq[k]); end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL loop_done_count got=%0d exp=1", done_cnt); end
      checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL loop_busy_end got=%b exp=0", io_busy); end
   endtask

   task automatic test_skip_zero();
      int lim;
      gen_auto = 1'b1; hold_stale = 1'b1;
      apply_reset();
      rand_entry(0, int'($urandom_range(1, 3)));
      rand_entry(1, 0);
      clear_mon();
      io_stream_mask = 4'b0011; io_loop = 1'b0;
      pulse_start();
      lim = 0;
      while (done_cnt == 0 && lim < 1000) begin tick(); lim++; end
      tick(2);
      checks++; if (visits.size() != 1) begin failures++; $display("FAIL skip_visit_count got=%0d exp=1", visits.size()); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL skip_done_count got=%0d exp=1", done_cnt); end
      clear_mon();
      io_loop = 1'b1;
      pulse_start();
      lim = 0;
      while (visits.size() < 3 && lim < 2000) begin tick(); lim++; end
      checks++; if (io_pass_cnt !== 16'd2) begin failures++; $display("FAIL skip_loop_pass_cnt got=%0d exp=2", io_pass_cnt); end
      io_stop = 1'b1; tick(); io_stop = 1'b0;
      lim = 0;
      while (done_cnt == 0 && lim < 100) begin tick(); lim++; end
      for (int k = 0; k < visits.size(); k++) begin
         checks++; if (visits[k].idx != 0) begin failures++; $display("FAIL skip_loop_idx k=%0d got=%0d exp=0", k, visits[k].idx); end
      end
      checks++; if (en_on_1 != 0) begin failures++; $display("FAIL skip_enable_on_1 got=%0d exp=0", en_on_1); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL skip_loop_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_stop_drain();
      int lim;
      gen_auto = 1'b0;
      apply_reset();
      rand_entry(0, 5);
      clear_mon();
      io_stream_mask = 4'b0001; io_loop = 1'b0;
      pulse_start();
      lim = 0;
      while (!io_gen_enable && lim < 20) begin tick(); lim++; end
      io_gen_tx_en = 1'b1;
      tick(3);
      io_stop = 1'b1; tick(); io_stop = 1'b0;
      checks++; if (io_gen_enable !== 1'b0) begin failures++; $display("FAIL stop_enable_drop got=%b exp=0", io_gen_enable); end
      repeat (20) tick();
      checks++; if (done_cnt != 0 || io_busy !== 1'b1) begin failures++; $display("FAIL stop_drain_hold got done=%0d busy=%b exp done=0 busy=1", done_cnt, io_busy); end
      io_gen_tx_en = 1'b0;
      tick();
      checks++; if (io_done !== 1'b1) begin failures++; $display("FAIL stop_done_pulse got=%b exp=1", io_done); end
      checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL stop_idle got=%b exp=0", io_busy); end
      tick();
      checks++; if (io_done !== 1'b0 || done_cnt != 1) begin failures++; $display("FAIL stop_done_single got done=%b cnt=%0d exp 0/1", io_done, done_cnt); end
   endtask

   task automatic test_idle_ignore();
      int lim;
      gen_auto = 1'b1; hold_stale = 1'b0;
      apply_reset();
      rand_entry(0, int'($urandom_range(1, 3)));
      clear_mon();
      io_stream_mask = 4'b0000;
      pulse_start();
      tick(3);
      checks++; if (io_busy !== 1'b0 || done_cnt != 0) begin failures++; $display("FAIL idle_zero_mask got busy=%b done=%0d exp 0/0", io_busy, done_cnt); end
      io_stream_mask = 4'b0001;
      io_start = 1'b1; io_stop = 1'b1; tick(); io_start = 1'b0; io_stop = 1'b0;
      tick(2);
      checks++; if (io_busy !== 1'b0 || done_cnt != 0) begin failures++; $display("FAIL idle_start_stop got busy=%b done=%0d exp 0/0", io_busy, done_cnt); end
      io_stop = 1'b1; tick(); io_stop = 1'b0;
      tick(2);
      checks++; if (io_busy !== 1'b0 || done_cnt != 0) begin failures++; $display("FAIL idle_stop_only got busy=%b done=%0d exp 0/0", io_busy, done_cnt); end
      pulse_start();
      tick(3);
      pulse_start();
      lim = 0;
      while (done_cnt == 0 && lim < 500) begin tick(); lim++; end
      tick(4);
      checks++; if (visits.size() != 1 || done_cnt != 1) begin failures++; $display("FAIL busy_start_ignored got visits=%0d done=%0d exp 1/1", visits.size(), done_cnt); end
   endtask

   task automatic test_cfg_write_and_reset();
      int lim;
      logic [47:0] da0;
      gen_auto = 1'b0;
      apply_reset();
      rand_entry(0, 4);
      da0 = m_da[0];
      clear_mon();
      io_stream_mask = 4'b0001; io_loop = 1'b1;
      pulse_start();
      lim = 0;
      while (!io_gen_enable && lim < 20) begin tick(); lim++; end
      checks++; if (io_gen_da !== da0) begin failures++; $display("FAIL cfg_da_loaded got=%0h exp=%0h", io_gen_da, da0); end
      write_entry(0, 48'h0, m_sa[0], m_et[0], m_len[0], m_pm[0], m_cnt[0]);
      tick();
      checks++; if (io_gen_da !== da0 || io_gen_enable !== 1'b1) begin failures++; $display("FAIL cfg_da_held got=%0h en=%b exp=%0h en=1", io_gen_da, io_gen_enable, da0); end
      io_gen_send_done = 1'b1; tick(); io_gen_send_done = 1'b0;
      checks++; if (io_gen_enable !== 1'b0) begin failures++; $display("FAIL cfg_done_drop got=%b exp=0", io_gen_enable); end
      lim = 0;
      while (!io_gen_enable && lim < 20) begin tick(); lim++; end
      checks++; if (io_gen_da !== m_da[0]) begin failures++; $display("FAIL cfg_da_reloaded got=%0h exp=%0h", io_gen_da, m_da[0]); end
      checks++; if (io_pass_cnt !== 16'd1) begin failures++; $display("FAIL cfg_pass_cnt got=%0d exp=1", io_pass_cnt); end
      tick(2);
      reset_n = 1'b0;
      #1;
      checks++; if (io_gen_enable !== 1'b0 || io_busy !== 1'b0 || io_done !== 1'b0) begin failures++; $display("FAIL async_reset got en=%b busy=%b done=%b exp 0/0/0", io_gen_enable, io_busy, io_done); end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_loop();
      test_skip_zero();
      test_stop_drain();
      test_idle_ignore();
      test_cfg_write_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
